// File: rtl/mdu_pkg.sv
// Shared op codes, op-class predicates and default latencies for the MD unit.
// Build option: define MDU_MADD_EN to accept the madd/msub family (ops 7-10).
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic is_macc(input logic [3:0] op);
    return MADD_EN && (op >= OP_MADD) && (op <= OP_MSUBU);
  endfunction

  // Accumulate ops share the multiplier latency, so they count as mult-class.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_macc(op);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return is_long(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result datapath: next {HI,LO} from the latched op and operands.
// Build option: MDU_MADD_EN compiles the accumulate path.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);

  logic        sgn;
  logic [63:0] prod;
  logic [31:0] ua, ub, uq, ur, q, r;

  assign sgn  = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign prod = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'b0, a} * {32'b0, b};

  // Signed divide on magnitudes: quotient sign is the XOR of operand signs,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  assign ua = (sgn && a[31]) ? -a : a;
  assign ub = (sgn && b[31]) ? -b : b;
  assign uq = (ub == 32'd0) ? 32'd0 : ua / ub;
  assign ur = (ub == 32'd0) ? 32'd0 : ua % ub;
  assign q  = (sgn && (a[31] ^ b[31])) ? -uq : uq;
  assign r  = (sgn && a[31]) ? -ur : ur;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    hi_n = hi;
    lo_n = lo;
    case (op)
      OP_MULT, OP_MULTU: {hi_n, lo_n} = prod;
      OP_DIV, OP_DIVU: begin
        if (b != 32'd0) begin
          hi_n = r;
          lo_n = q;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: {hi_n, lo_n} = acc + prod;
      OP_MSUB, OP_MSUBU: {hi_n, lo_n} = acc - prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide scheduler: latches operands, counts out latency,
// commits HI/LO and raises md_stall. Build option: MDU_MADD_EN.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_hilo_sel,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] E_md_rdata
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_n, lo_n;

  mdu_arith u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi),
    .lo   (lo),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (E_start) begin
            if (is_long(E_mdop)) begin
              state <= S_RUN;
              busy  <= 1'b1;
              op_q  <= E_mdop;
              a_q   <= E_rs_val;
              b_q   <= E_rt_val;
              cnt   <= is_div(E_mdop) ? DIV_N : MUL_N;
            end else if (E_mdop == OP_MTHI) begin
              hi <= E_rs_val;
            end else if (E_mdop == OP_MTLO) begin
              lo <= E_rs_val;
            end
          end
        end
        S_RUN: begin
          // Issues arriving here are dropped; the hazard unit holds them in D.
          if (cnt == 4'd1) begin
            hi    <= hi_n;
            lo    <= lo_n;
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md_stall   = D_md_use & (busy | (E_start & is_md(E_mdop)));
  assign E_md_rdata = E_hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_mdu_sched;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        E_start = 1'b0;
  logic [3:0]  E_mdop = 4'd0;
  logic [31:0] E_rs_val = 32'd0;
  logic [31:0] E_rt_val = 32'd0;
  logic        E_hilo_sel = 1'b0;
  logic        D_md_use = 1'b0;
  logic        busy, md_stall;
  logic [31:0] hi, lo, E_md_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  mdu_sched dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_mdop(E_mdop),
    .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .E_hilo_sel(E_hilo_sel),
    .D_md_use(D_md_use), .busy(busy), .md_stall(md_stall),
    .hi(hi), .lo(lo), .E_md_rdata(E_md_rdata)
  );

  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MUL_N;
    if (op == 4'd3 || op == 4'd4) return DIV_N;
    if (MADD && op >= 4'd7 && op <= 4'd10) return MUL_N;
    return 0;
  endfunction

  // Reference: results from 64-bit integer arithmetic on the architectural rules.
  function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {mhi, mlo};
    case (op)
      4'd1: {mhi, mlo} = 64'(sa * sb);
      4'd2: {mhi, mlo} = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        mlo = q[31:0]; mhi = r[31:0];
      end
      4'd4: if (b != 0) begin
        mlo = a / b; mhi = a % b;
      end
      4'd5: mhi = a;
      4'd6: mlo = a;
      4'd7, 4'd8, 4'd9, 4'd10: if (MADD) begin
        p = (op == 4'd7 || op == 4'd9) ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
        {mhi, mlo} = (op <= 4'd8) ? acc + p : acc - p;
      end
      default: ;
    endcase
  endfunction

  // Issue one op at the next negedge, then count busy cycles (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk);
    E_start = 1'b1; E_mdop = op; E_rs_val = a; E_rt_val = b;
    @(posedge clk); #1;
    E_start = 1'b0; E_mdop = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", md_stall); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    @(posedge clk); #1; reset = 1'b0;
    mhi = 0; mlo = 0;
  endtask

  task automatic test_mult();
    int c;
    do_op(4'd1, 32'hFFFFFFFE, 32'd3, c); model_apply(4'd1, 32'hFFFFFFFE, 32'd3);
    checks++; if (c != MUL_N) begin errors++; $display("FAIL mult_busy got=%0d exp=%0d", c, MUL_N); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_res got=%h/%h exp=ffffffff/fffffffa", hi, lo); end
  endtask

  task automatic test_div();
    int c;
    do_op(4'd4, 32'd100, 32'd7, c); model_apply(4'd4, 32'd100, 32'd7);
    checks++; if (c != DIV_N) begin errors++; $display("FAIL divu_busy got=%0d exp=%0d", c, DIV_N); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_res got=%h/%h exp=2/e", hi, lo); end
    do_op(4'd3, -32'sd7, 32'd2, c); model_apply(4'd3, -32'sd7, 32'd2);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_res got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    int seen;
    seen = 0;
    @(negedge clk);
    E_start = 1'b1; E_mdop = 4'd5; E_rs_val = 32'h1234;
    @(posedge clk); #1;
    seen |= int'(busy);
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got=%h exp=1234", hi); end
    E_mdop = 4'd6; E_rs_val = 32'h5678;
    @(posedge clk); #1;
    E_start = 1'b0; E_mdop = 4'd0;
    seen |= int'(busy);
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got=%h exp=5678", lo); end
    checks++; if (seen != 0) begin errors++; $display("FAIL mt_busy got=%0d exp=0", seen); end
    mhi = 32'h1234; mlo = 32'h5678;
    E_hilo_sel = 1'b1; #1;
    checks++; if (E_md_rdata !== mhi) begin errors++; $display("FAIL rdata_hi got=%h exp=%h", E_md_rdata, mhi); end
    E_hilo_sel = 1'b0; #1;
    checks++; if (E_md_rdata !== mlo) begin errors++; $display("FAIL rdata_lo got=%h exp=%h", E_md_rdata, mlo); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    @(negedge clk);
    D_md_use = 1'b1; E_start = 1'b1; E_mdop = 4'd1; E_rs_val = 32'd9; E_rt_val = 32'd9;
    #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_issue got=%0h exp=1", md_stall); end
    @(posedge clk); #1;
    E_start = 1'b0; E_mdop = 4'd0;
    for (int i = 0; i < MUL_N; i++) begin
      if (md_stall !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    model_apply(4'd1, 32'd9, 32'd9);
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_run got=%0d low cycles exp=0", bad); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_after got=%0h exp=0", md_stall); end
    E_start = 1'b1; E_mdop = 4'd13; #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_undef got=%0h exp=0", md_stall); end
    E_mdop = 4'd7; #1;
    checks++; if (md_stall !== MADD) begin errors++; $display("FAIL stall_madd got=%0h exp=%0h", md_stall, MADD); end
    E_start = 1'b0; E_mdop = 4'd0; D_md_use = 1'b0;
  endtask

  task automatic test_div0();
    int c;
    do_op(4'd5, 32'hAAAA, 32'd0, c); do_op(4'd6, 32'h5555, 32'd0, c);
    mhi = 32'hAAAA; mlo = 32'h5555;
    do_op(4'd3, 32'd77, 32'd0, c);
    checks++; if (c != DIV_N) begin errors++; $display("FAIL div0_busy got=%0d exp=%0d", c, DIV_N); end
    checks++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin errors++; $display("FAIL div0_hold got=%h/%h exp=aaaa/5555", hi, lo); end
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, c); model_apply(4'd3, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (lo !== 32'h80000000 || hi !== 32'd0) begin errors++; $display("FAIL div_ovf got=%h/%h exp=0/80000000", hi, lo); end
  endtask

  task automatic test_ignore();
    int c;
    @(negedge clk);
    E_start = 1'b1; E_mdop = 4'd4; E_rs_val = 32'd1000; E_rt_val = 32'd33;
    @(posedge clk); #1;
    E_mdop = 4'd5; E_rs_val = 32'hDEAD;
    @(posedge clk); #1;
    E_mdop = 4'd1; E_rs_val = 32'd3; E_rt_val = 32'd3;
    @(posedge clk); #1;
    E_start = 1'b0; E_mdop = 4'd0;
    c = 0;
    while (busy === 1'b1 && c < 40) begin c++; @(posedge clk); #1; end
    model_apply(4'd4, 32'd1000, 32'd33);
    checks++; if (hi !== mhi || lo !== mlo) begin errors++; $display("FAIL ignore got=%h/%h exp=%h/%h", hi, lo, mhi, mlo); end
  endtask

  task automatic test_reset_mid();
    int c;
    do_op(4'd5, 32'h77, 32'd0, c);
    @(negedge clk);
    E_start = 1'b1; E_mdop = 4'd1; E_rs_val = 32'd4; E_rt_val = 32'd4;
    @(posedge clk); #1;
    E_start = 1'b0; E_mdop = 4'd0;
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid got=%0h %h/%h exp=0 0/0", busy, hi, lo); end
    @(posedge clk); #1; reset = 1'b0;
    repeat (8) @(posedge clk); #1;
    mhi = 0; mlo = 0;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_nocommit got=%0h %h/%h exp=0 0/0", busy, hi, lo); end
  endtask

  task automatic test_madd();
    int c;
    do_op(4'd5, 32'd0, 32'd0, c); do_op(4'd6, 32'd5, 32'd0, c);
    mhi = 0; mlo = 5;
    do_op(4'd7, 32'd2, 32'd3, c); model_apply(4'd7, 32'd2, 32'd3);
    checks++; if (c != exp_cycles(4'd7)) begin errors++; $display("FAIL madd_busy got=%0d exp=%0d", c, exp_cycles(4'd7)); end
    checks++; if (hi !== mhi || lo !== mlo) begin errors++; $display("FAIL madd_res got=%h/%h exp=%h/%h", hi, lo, mhi, mlo); end
  endtask

  task automatic test_back_to_back();
    int c, bad;
    logic [3:0] op;
    logic [31:0] a, b;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(op, a, b, c);
      model_apply(op, a, b);
      if (c != exp_cycles(op)) bad++;
      checks++; if (hi !== mhi || lo !== mlo) begin errors++; $display("FAIL rand%0d op=%0d got=%h/%h exp=%h/%h", i, op, hi, lo, mhi, mlo); end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_latency got=%0d wrong exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_stall();
    test_div0();
    test_ignore();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
